serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_f_adder.sv | 30 +++
 rtl/serial_adder.sv | 148 ++++++++++++++
 tb/tb_serial_adder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encodings,
//   the default operand width and the bit-counter width helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must index bits 0..width-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_f_adder.sv
// f_adder
//   Combinational full adder built from two half-adder cells and an OR gate.
//   Ports:
//     a, b  : operand bits
//     ci    : carry in
//     so    : sum out
//     co    : carry out
module f_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic so,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // first half adder: a + b
    assign ha0_s = a ^ b;
    assign ha0_c = a & b;

    // second half adder: partial sum + carry in
    assign so    = ha0_s ^ ci;
    assign ha1_c = ha0_s & ci;

    assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop,
//   producing one sum bit per clock, LSB first.
//   Optional macro SERIAL_ADDER_OVF_EN adds a registered two's-complement
//   overflow output ovf.
//   Ports:
//     clk    : system clock, rising edge
//     rst    : synchronous active-high reset
//     start  : request pulse, accepted only while ready
//     a, b   : operands, latched on accepted start
//     ci     : carry in, latched on accepted start
//     ready  : high in IDLE and DONE
//     busy   : high in RUN
//     done   : one-cycle pulse when sum/co are updated
//     sum    : registered result, held until the next result
//     co     : registered carry out
//     ovf    : (SERIAL_ADDER_OVF_EN only) registered signed overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam int            RW   = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Only WIDTH-1 bits are kept; the final bit goes straight into sum.
    logic [RW-1:0]    res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_so;
    logic fa_co;

    f_adder u_f_adder (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .so (fa_so),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = RW'({fa_so, res_q} >> 1);
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    sum_d   = {fa_so, res_q};
                    co_d    = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this last bit
                    ovf_d   = carry_q ^ fa_co;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign co    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         busy_run = 0;
    logic [9:0] exp_q[$];
    int         done_cyc[$];
    logic [9:0] e;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // {ovf, co, sum}
    function automatic logic [9:0] mk(input logic [7:0] s, input logic c, input logic v);
        return {v, c, s};
    endfunction

    // Monitor: pops one expected result per done pulse.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else begin
            if (done) begin
                check("busy_len", busy_run, WIDTH);
                done_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no request outstanding, sum=%0h", sum);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", sum, e[7:0]);
                    check("co", co, e[8]);
`ifdef SERIAL_ADDER_OVF_EN
                    check("ovf", ovf, e[9]);
`endif
                end
            end
            busy_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic civ,
                         input logic [9:0] ev, input bit push);
        int n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_before_start", ready, 1);
        a = av;
        b = bv;
        ci = civ;
        start = 1'b1;
        if (push) exp_q.push_back(ev);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    initial begin
        int acc;
        int nd0;
        int n;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        ci = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_sum", sum, 0);
        check("rst_co", co, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 1);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        tick();

        // basic add plus latency
        nd0 = done_cyc.size();
        issue(8'h3C, 8'h05, 1'b0, mk(8'h41, 1'b0, 1'b0), 1);
        acc = cyc;
        wait_empty(50);
        check("basic_done_count", done_cyc.size() - nd0, 1);
        if (done_cyc.size() > nd0) check("latency", done_cyc[nd0] - acc, WIDTH);
        check("hold_sum_idle", sum, 8'h41);

        // carry chain
        issue(8'hFF, 8'h00, 1'b1, mk(8'h00, 1'b1, 1'b0), 1);
        wait_empty(50);

        // signed overflow, no carry out
        issue(8'h7F, 8'h01, 1'b0, mk(8'h80, 1'b0, 1'b1), 1);
        wait_empty(50);

        // start during RUN is ignored
        nd0 = done_cyc.size();
        issue(8'h10, 8'h20, 1'b0, mk(8'h30, 1'b0, 1'b0), 1);
        tick();
        tick();
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_empty(50);
        tick();
        tick();
        check("run_start_ignored", done_cyc.size() - nd0, 1);

        // back-to-back with start held high
        nd0 = done_cyc.size();
        a = 8'h01;
        b = 8'h01;
        ci = 1'b0;
        start = 1'b1;
        exp_q.push_back(mk(8'h02, 1'b0, 1'b0));
        tick();
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        a = 8'h02;
        b = 8'h02;
        exp_q.push_back(mk(8'h04, 1'b0, 1'b0));
        tick();
        start = 1'b0;
        wait_empty(50);
        check("b2b_done_count", done_cyc.size() - nd0, 2);
        if (done_cyc.size() >= nd0 + 2)
            check("b2b_spacing", done_cyc[nd0 + 1] - done_cyc[nd0], WIDTH + 1);

        // reset in the middle of RUN aborts without done
        nd0 = done_cyc.size();
        issue(8'h33, 8'h44, 1'b0, '0, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_sum", sum, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 1);
        tick();
        repeat (12) tick();
        check("abort_no_done", done_cyc.size() - nd0, 0);
        issue(8'h01, 8'h01, 1'b0, mk(8'h02, 1'b0, 1'b0), 1);
        wait_empty(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
